// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation mode encoding and sequencer state encoding.
package alu_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : alu_pkg

// File: rtl/addsub_chunk.sv
// Purely combinational CHUNK-bit adder slice with carry-in, carry-out and
// signed overflow (carry into the MSB xor carry out of the MSB).
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [CHUNK:0] full;
  logic           c_into_msb;

  // Widen by one bit so the carry out falls into full[CHUNK].
  always_comb begin
    full       = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    sum        = full[CHUNK-1:0];
    cout       = full[CHUNK];
    // The MSB sum bit is x^y^carry_in, so the carry into the MSB falls out of it.
    c_into_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ sum[CHUNK-1];
    ovf        = c_into_msb ^ cout;
  end

endmodule : addsub_chunk

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract unit processing CHUNK bits per clock,
// with start/busy/done handshake and carry/borrow/overflow/zero flags.
module addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int K     = WIDTH / CHUNK;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cout_q, cout_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [CHUNK-1:0]       ch_sum;
  logic                   ch_cout;
  logic                   ch_ovf;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (sa_q[CHUNK-1:0]),
    .y    (sb_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout),
    .ovf  (ch_ovf)
  );

  // Result register fills from the top, so after K steps chunk 0 sits at the bottom.
  always_comb begin
    acc_cat  = {ch_sum, acc_q};
    acc_next = acc_cat[WIDTH+CHUNK-1:CHUNK];
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    res_d    = res_q;
    cout_d   = cout_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
          sb_d    = (mode == MODE_SUB) ? ~b : b;
          carry_d = mode;
          mode_d  = mode;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d    = sa_q >> CHUNK;
        sb_d    = sb_q >> CHUNK;
        carry_d = ch_cout;
        acc_d   = acc_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(K - 1)) begin
          res_d    = acc_next;
          cout_d   = ch_cout;
          borrow_d = mode_q & ~ch_cout;
          ovf_d    = ch_ovf;
          zero_d   = (acc_next == '0);
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      // NOTE: shift registers are cleared too, so a reset leaves no stale operand behind.
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign res    = res_q;
  assign cout   = cout_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule : addsub_seq
